// File: rtl/load_store_unit.sv
// load_store_unit
// Multi-cycle load/store initiator between the core execute stage and a
// synchronous 32-bit word RAM. One request is handled at a time. Byte and
// halfword stores are performed as read-modify-write.
//
// Ports:
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   req            request strobe, sampled only while idle
//   we             1 = store, 0 = load
//   funct3         size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   addr           byte address (bits above ADDR_W+1 ignored)
//   wdata          store data (low byte/half used for B/H)
//   busy           high whenever an access is in progress
//   done           one-cycle completion pulse
//   err            valid with done: misaligned or illegal funct3
//   rdata          extended load result, held until the next load completes
//   mem_address    RAM word address
//   mem_data       RAM write data
//   mem_rden       RAM read enable
//   mem_wren       RAM write enable
//   mem_q          RAM read data, valid the cycle after mem_rden is sampled
module load_store_unit #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_data,
  output logic              mem_rden,
  output logic              mem_wren,
  input  logic [31:0]       mem_q
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t              state;
  state_t              state_next;
  logic                op_we;
  logic [2:0]          op_funct3;
  logic [ADDR_W+1:0]   op_addr;
  logic [31:0]         op_wdata;
  logic [31:0]         merge;
  logic                err_flag;
  logic                req_error;

  // Upper address bits wrap within the RAM and are deliberately dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:ADDR_W+2];

  // Illegal size/sign code or misaligned address for the requested size.
  function automatic logic access_error(input logic is_store, input logic [2:0] f3,
                                        input logic [1:0] lo);
    logic e;
    case (f3)
      3'b000:  e = 1'b0;
      3'b001:  e = lo[0];
      3'b010:  e = (lo != 2'b00);
      3'b100:  e = is_store;
      3'b101:  e = is_store | lo[0];
      default: e = 1'b1;
    endcase
    return e;
  endfunction

  // Select the addressed lane of a RAM word and sign/zero extend it.
  function automatic logic [31:0] load_extend(input logic [31:0] q, input logic [2:0] f3,
                                              input logic [1:0] lo);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lo)
      2'd0:    b = q[7:0];
      2'd1:    b = q[15:8];
      2'd2:    b = q[23:16];
      2'd3:    b = q[31:24];
      default: b = 8'd0;
    endcase
    h = lo[1] ? q[31:16] : q[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'd0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'd0, h};
      default: r = q;
    endcase
    return r;
  endfunction

  // Replace the addressed byte/half of the old RAM word with store data.
  function automatic logic [31:0] store_merge(input logic [31:0] q, input logic [31:0] wd,
                                              input logic [2:0] f3, input logic [1:0] lo);
    logic [31:0] r;
    if (f3 == 3'b001) begin
      r = lo[1] ? {wd[15:0], q[15:0]} : {q[31:16], wd[15:0]};
    end else begin
      case (lo)
        2'd0:    r = {q[31:8], wd[7:0]};
        2'd1:    r = {q[31:16], wd[7:0], q[7:0]};
        2'd2:    r = {q[31:24], wd[7:0], q[15:0]};
        2'd3:    r = {wd[7:0], q[23:0]};
        default: r = q;
      endcase
    end
    return r;
  endfunction

  assign req_error = access_error(we, funct3, addr[1:0]);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; word stores skip the read phase, errors skip the RAM.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (req) begin
          if (req_error) begin
            state_next = S_DONE;
          end else if (we && (funct3 == 3'b010)) begin
            state_next = S_WR;
          end else begin
            state_next = S_RD;
          end
        end else begin
          state_next = S_IDLE;
        end
      end
      S_RD:    state_next = S_CAP;
      S_CAP:   state_next = op_we ? S_WR : S_DONE;
      S_WR:    state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Operand latch on acceptance, load result and merge word capture in CAP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_we     <= 1'b0;
      op_funct3 <= 3'd0;
      op_addr   <= '0;
      op_wdata  <= 32'd0;
      err_flag  <= 1'b0;
      merge     <= 32'd0;
      rdata     <= 32'd0;
    end else begin
      if ((state == S_IDLE) && req) begin
        op_we     <= we;
        op_funct3 <= funct3;
        op_addr   <= addr[ADDR_W+1:0];
        op_wdata  <= wdata;
        err_flag  <= req_error;
      end
      if (state == S_CAP) begin
        if (op_we) begin
          merge <= store_merge(mem_q, op_wdata, op_funct3, op_addr[1:0]);
        end else begin
          rdata <= load_extend(mem_q, op_funct3, op_addr[1:0]);
        end
      end
    end
  end

  // Outputs decode from the state register and latched operands only.
  always_comb begin
    busy        = (state != S_IDLE);
    done        = (state == S_DONE);
    err         = (state == S_DONE) & err_flag;
    mem_rden    = (state == S_RD);
    mem_wren    = (state == S_WR);
    mem_address = op_addr[ADDR_W+1:2];
    if (state == S_WR) begin
      mem_data = (op_funct3 == 3'b010) ? op_wdata : merge;
    end else begin
      mem_data = 32'd0;
    end
  end

endmodule
